psl_request_scheduler: RTL and testbench
========================================

Name: psl_request_scheduler

Overview:
- Sequences one probabilistic-solver (psl) instance per query: accepts a query, holds the psl operands and MODE stable, and asserts pending_request for a burn-in period followed by a sampling period.
- Takes a per-bit majority vote of psl_out at each sweep boundary during sampling and returns a single deterministic 4-bit answer over a valid/ready handshake.
- Sits between the host/UART command layer and the psl core.

Parameters:
- OUT_W, 4, width of psl_out / response data (P2+1)
- IN_W, 2, width of each operand in1/in2 (P3+1)
- SWEEP_CYCLES, 12, clocks per full psl sweep (3 per updated pbit x OUT_W)
- BURN_SWEEPS, 16, sweeps discarded before sampling; legal range 1..255
- SAMPLE_SWEEPS, 15, sweeps sampled for the vote; must be odd, 1..255

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  query present
- req_ready  out  1  scheduler can accept a query
- req_mode  in  1  0 = forward (operands in, product out); 1 = inverse (product in, factors out)
- req_in1  in  IN_W  operand 1 (mode 0)
- req_in2  in  IN_W  operand 2 (mode 0)
- req_op  in  OUT_W  product (mode 1)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  OUT_W  majority-voted psl_out
- rsp_mode  out  1  echo of the query mode
- rsp_unanimous  out  1  every bit saw 0 or SAMPLE_SWEEPS ones
- psl_mode  out  1  to psl MODE
- psl_in1  out  IN_W  to psl in1
- psl_in2  out  IN_W  to psl in2
- psl_op  out  OUT_W  to psl op
- psl_pending  out  1  to psl pending_request
- psl_out  in  OUT_W  from psl psl_out

Behaviour:
- **Reset values:** state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_mode=0; rsp_unanimous=0; psl_pending=0; psl_* operand regs=0; all counters=0.
- **Reset mid-query:** abandons the query with no response; psl_pending drops on the next edge.
- **FSM states:** IDLE, SETTLE, BURN, SAMPLE, DONE.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch mode/in1/in2/op into psl_* registers, clear vote counters, go to SETTLE.
  - Operands stay frozen until the next accept.
- **SETTLE:**
  - psl_pending=1 for exactly 1 cycle; this covers the psl "first" cycle.
  - cyc_cnt=0, sweep_cnt=0, then go to BURN.
- **BURN:**
  - cyc_cnt counts 0..SWEEP_CYCLES-1 and wraps to 0; sweep_cnt increments on each wrap.
  - When sweep_cnt reaches BURN_SWEEPS-1 and cyc_cnt reaches SWEEP_CYCLES-1, clear both counters and go to SAMPLE.
- **SAMPLE:**
  - Same counting as BURN.
  - At cyc_cnt==SWEEP_CYCLES-1, add psl_out[b] to ones_cnt[b] for every bit b. ones_cnt width is $clog2(SAMPLE_SWEEPS+1), no saturation needed.
  - After SAMPLE_SWEEPS samples, go to DONE.
- **DONE:**
  - psl_pending=0; rsp_valid=1.
  - rsp_data[b] = (ones_cnt[b] > SAMPLE_SWEEPS/2), registered on DONE entry.
  - rsp_unanimous = AND over b of (ones_cnt[b]==0 || ones_cnt[b]==SAMPLE_SWEEPS).
  - Hold rsp_* stable while rsp_valid && !rsp_ready; on rsp_ready go to IDLE.
- **psl_pending:** 1 exactly in SETTLE, BURN and SAMPLE; 0 in IDLE and DONE. Dropping it resets the psl sequencer between queries.
- **Latency:**
  - Accept edge t gives rsp_valid at edge t+1+(BURN_SWEEPS+SAMPLE_SWEEPS)*SWEEP_CYCLES.
  - With default parameters that is 373 cycles.
  - Throughput is one query in flight; req_ready=0 from SETTLE through DONE.
- **Simultaneous events:**
  - The new req_valid is not accepted in the same cycle as the DONE handshake; it is accepted on the following IDLE cycle.
  - req_valid changes while busy are ignored.

Decomposition:
- **Shared package psl_pkg:**
  - psl_state_t enum (IDLE, SETTLE, BURN, SAMPLE, DONE).
  - Localparams OUT_W/IN_W derived from P.
  - SWEEP_CYCLES = 3*OUT_W.
- **Sub-module psl_vote_acc:** per-bit ones counters, clear/accumulate enable, majority and unanimous outputs; instantiated once.
- The FSM and counters stay in the top module.

Test Plan:
- Bench psl stub drives psl_out=4'b0110 constantly, query mode0 in1=2'b10 in2=2'b11 → rsp_valid exactly 373 cycles after accept, rsp_data=4'b0110, rsp_unanimous=1, rsp_mode=0. psl_pending is high for exactly 373 cycles, 1 (SETTLE) + 192 (BURN) + 180 (SAMPLE), dropping on the same edge rsp_valid rises.
- Stub drives 4'b1111 on 8 of 15 sample points, 4'b0000 on 7 → rsp_data=4'b1111, rsp_unanimous=0. With 7 of 15 ones → rsp_data=4'b0000.
- Stub drives 4'b1111 during BURN and 4'b0001 during SAMPLE → rsp_data=4'b0001, proving burn-in samples are discarded.
- Mode1 query op=4'b0110 → psl_mode=1 and psl_op=4'b0110 held constant for the whole query; req_ready=0 throughout; a second req_valid while busy is not accepted.
- Hold rsp_ready=0 for 50 cycles in DONE → rsp_valid/rsp_data stable, psl_pending=0. Then rsp_ready=1 → IDLE, req_ready=1 next cycle.
- Assert RST for 1 cycle mid-SAMPLE → next cycle: psl_pending=0, req_ready=1, rsp_valid=0. A fresh query then completes normally with counters cleared.

Source files
------------

// File: rtl/psl_pkg.sv
// Shared types and default geometry for the psl request scheduler.
// The psl core is sized from P2/P3; a full sweep updates every pbit at 3 clocks each.
package psl_pkg;

    localparam int P2 = 3;
    localparam int P3 = 1;
    localparam int PSL_OUT_W        = P2 + 1;
    localparam int PSL_IN_W         = P3 + 1;
    localparam int PSL_SWEEP_CYCLES = 3 * PSL_OUT_W;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        BURN,
        SAMPLE,
        DONE
    } psl_state_t;

endpackage

// File: rtl/psl_vote_acc.sv
// Per-bit ones counters for the sampling-phase majority vote.
// Vote outputs look at the next-cycle counts so the final sample lands in the registered answer.
module psl_vote_acc #(
    parameter int OUT_W   = 4,
    parameter int SAMPLES = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             acc_en,
    input  logic [OUT_W-1:0] bits,
    output logic [OUT_W-1:0] majority,
    output logic             unanimous
);

    localparam int CNT_W = $clog2(SAMPLES + 1);

    logic [CNT_W-1:0] ones_cnt     [OUT_W];
    logic [CNT_W-1:0] ones_cnt_nxt [OUT_W];

    always_comb begin
        majority  = '0;
        unanimous = 1'b1;
        for (int b = 0; b < OUT_W; b++) begin
            ones_cnt_nxt[b] = ones_cnt[b];
            if (clr)
                ones_cnt_nxt[b] = '0;
            else if (acc_en)
                ones_cnt_nxt[b] = ones_cnt[b] + CNT_W'(bits[b]);
            majority[b] = (ones_cnt_nxt[b] > CNT_W'(SAMPLES / 2));
            unanimous   = unanimous & ((ones_cnt_nxt[b] == '0) ||
                                       (ones_cnt_nxt[b] == CNT_W'(SAMPLES)));
        end
    end

    always_ff @(posedge CLK) begin
        for (int b = 0; b < OUT_W; b++) begin
            if (RST)
                ones_cnt[b] <= '0;
            else
                ones_cnt[b] <= ones_cnt_nxt[b];
        end
    end

endmodule

// File: rtl/psl_request_scheduler.sv
// Runs one psl query at a time: freeze operands, burn in, sample at sweep boundaries,
// and hand back the per-bit majority answer over a valid/ready handshake.
module psl_request_scheduler
    import psl_pkg::*;
#(
    parameter int OUT_W         = PSL_OUT_W,
    parameter int IN_W          = PSL_IN_W,
    parameter int SWEEP_CYCLES  = PSL_SWEEP_CYCLES,
    parameter int BURN_SWEEPS   = 16,
    parameter int SAMPLE_SWEEPS = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_mode,
    input  logic [IN_W-1:0]  req_in1,
    input  logic [IN_W-1:0]  req_in2,
    input  logic [OUT_W-1:0] req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [OUT_W-1:0] rsp_data,
    output logic             rsp_mode,
    output logic             rsp_unanimous,
    output logic             psl_mode,
    output logic [IN_W-1:0]  psl_in1,
    output logic [IN_W-1:0]  psl_in2,
    output logic [OUT_W-1:0] psl_op,
    output logic             psl_pending,
    input  logic [OUT_W-1:0] psl_out
);

    localparam int CYC_W = $clog2(SWEEP_CYCLES + 1);
    localparam int SWP_W = 8;

    psl_state_t       state, state_nxt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [SWP_W-1:0] sweep_cnt;
    logic             last_cyc;
    logic             acc_clr, acc_en;
    logic [OUT_W-1:0] vote_maj;
    logic             vote_unan;

    always_comb begin
        state_nxt = state;
        last_cyc  = (cyc_cnt == CYC_W'(SWEEP_CYCLES - 1));
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SETTLE;
                    acc_clr   = 1'b1;
                end
            end
            SETTLE: state_nxt = BURN;
            BURN: begin
                if (last_cyc && sweep_cnt == SWP_W'(BURN_SWEEPS - 1))
                    state_nxt = SAMPLE;
            end
            SAMPLE: begin
                acc_en = last_cyc;
                if (last_cyc && sweep_cnt == SWP_W'(SAMPLE_SWEEPS - 1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready   = (state == IDLE);
    assign psl_pending = (state == SETTLE) || (state == BURN) || (state == SAMPLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            cyc_cnt       <= '0;
            sweep_cnt     <= '0;
            psl_mode      <= 1'b0;
            psl_in1       <= '0;
            psl_in2       <= '0;
            psl_op        <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            rsp_mode      <= 1'b0;
            rsp_unanimous <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        psl_mode <= req_mode;
                        psl_in1  <= req_in1;
                        psl_in2  <= req_in2;
                        psl_op   <= req_op;
                    end
                end
                SETTLE: begin
                    cyc_cnt   <= '0;
                    sweep_cnt <= '0;
                end
                BURN, SAMPLE: begin
                    if (state_nxt != state) begin
                        cyc_cnt   <= '0;
                        sweep_cnt <= '0;
                    end else if (last_cyc) begin
                        cyc_cnt   <= '0;
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // Answer is captured once on DONE entry and held until the consumer takes it.
            if (state == SAMPLE && state_nxt == DONE) begin
                rsp_valid     <= 1'b1;
                rsp_data      <= vote_maj;
                rsp_mode      <= psl_mode;
                rsp_unanimous <= vote_unan;
            end else if (state == DONE && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    psl_vote_acc #(
        .OUT_W   (OUT_W),
        .SAMPLES (SAMPLE_SWEEPS)
    ) u_vote (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (acc_clr),
        .acc_en    (acc_en),
        .bits      (psl_out),
        .majority  (vote_maj),
        .unanimous (vote_unan)
    );

endmodule

// File: tb/tb_psl_request_scheduler.sv
// Directed bench for psl_request_scheduler with a cycle-indexed psl_out stub.
module tb_psl_request_scheduler;

    localparam int SW        = 12;
    localparam int BURN      = 16;
    localparam int SAMP      = 15;
    localparam int LAT       = 1 + (BURN + SAMP) * SW;
    localparam int FIRST_SMP = 1 + BURN * SW + SW - 1;

    logic       CLK = 1'b0;
    logic       RST;
    logic       req_valid, req_ready, req_mode;
    logic [1:0] req_in1, req_in2;
    logic [3:0] req_op;
    logic       rsp_valid, rsp_ready, rsp_mode, rsp_unanimous;
    logic [3:0] rsp_data;
    logic       psl_mode, psl_pending;
    logic [1:0] psl_in1, psl_in2;
    logic [3:0] psl_op, psl_out;

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_cnt = 0;
    int          acc_edge = 0;
    int          stub_mode = 0;
    logic [3:0]  const_val = 4'h0;
    logic [3:0]  filler = 4'h0;
    logic [14:0] mask = '0;
    int          lat, pend, viol;
    logic [3:0]  held_data;

    psl_request_scheduler dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_mode      (req_mode),
        .req_in1       (req_in1),
        .req_in2       (req_in2),
        .req_op        (req_op),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_mode      (rsp_mode),
        .rsp_unanimous (rsp_unanimous),
        .psl_mode      (psl_mode),
        .psl_in1       (psl_in1),
        .psl_in2       (psl_in2),
        .psl_op        (psl_op),
        .psl_pending   (psl_pending),
        .psl_out       (psl_out)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Stub psl: output indexed by edges since the accept edge.
    always_comb begin
        int s;
        int k;
        s = edge_cnt - acc_edge;
        k = 0;
        psl_out = filler;
        case (stub_mode)
            0: psl_out = const_val;
            1: begin
                if (s >= FIRST_SMP && (s - FIRST_SMP) % SW == 0 && (s - FIRST_SMP) / SW < SAMP) begin
                    k = (s - FIRST_SMP) / SW;
                    psl_out = mask[k] ? 4'hF : 4'h0;
                end
            end
            default: psl_out = (s >= 1 && s <= BURN * SW) ? 4'hF : 4'h1;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_query(input logic mode, input logic [1:0] in1, input logic [1:0] in2,
                             input logic [3:0] op, input bit busy_req,
                             output int lat_o, output int pend_o, output int viol_o);
        logic       s_mode;
        logic [1:0] s_in1, s_in2;
        logic [3:0] s_op;
        req_mode  = mode;
        req_in1   = in1;
        req_in2   = in2;
        req_op    = op;
        req_valid = 1'b1;
        tick();
        acc_edge = edge_cnt;
        if (busy_req) begin
            req_mode = 1'b0;
            req_in1  = 2'b01;
            req_op   = 4'b1001;
        end else begin
            req_valid = 1'b0;
        end
        s_mode = psl_mode; s_in1 = psl_in1; s_in2 = psl_in2; s_op = psl_op;
        pend_o = psl_pending ? 1 : 0;
        viol_o = req_ready ? 1 : 0;
        lat_o  = 0;
        while (!rsp_valid && lat_o < 1000) begin
            tick();
            lat_o++;
            if (!rsp_valid) begin
                if (psl_pending) pend_o++;
                if (req_ready) viol_o++;
            end
            if (psl_mode !== s_mode || psl_in1 !== s_in1 || psl_in2 !== s_in2 || psl_op !== s_op)
                viol_o++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_in1 = '0; req_in2 = '0;
        req_op = '0; rsp_ready = 1'b0;
        tick(); tick();
        RST = 1'b0;
        tick();
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_rsp_mode", rsp_mode, 0);
        check_val("rst_rsp_unan", rsp_unanimous, 0);
        check_val("rst_pending", psl_pending, 0);
        check_val("rst_psl_ops", {psl_mode, psl_in1, psl_in2, psl_op}, 0);

        // Constant 0110, forward mode.
        stub_mode = 0; const_val = 4'b0110;
        run_query(1'b0, 2'b10, 2'b11, 4'b0000, 1'b0, lat, pend, viol);
        check_val("a_latency", lat, LAT);
        check_val("a_pending_cycles", pend, LAT);
        check_val("a_pending_at_valid", psl_pending, 0);
        check_val("a_busy_violations", viol, 0);
        check_val("a_psl_in", {psl_in1, psl_in2}, 4'b1011);
        check_val("a_rsp_data", rsp_data, 4'b0110);
        check_val("a_rsp_unan", rsp_unanimous, 1);
        check_val("a_rsp_mode", rsp_mode, 0);
        // Consumer stalls for 50 cycles.
        held_data = rsp_data;
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!rsp_valid || rsp_data !== held_data || psl_pending || req_ready) viol++;
        end
        check_val("stall_stable", viol, 0);
        handshake();
        check_val("hs_rsp_valid", rsp_valid, 0);
        check_val("hs_req_ready", req_ready, 1);

        // 8 of 15 samples all-ones; non-sample cycles zero.
        stub_mode = 1; mask = 15'b101010101010101; filler = 4'h0;
        run_query(1'b0, 2'b01, 2'b01, 4'b0000, 1'b0, lat, pend, viol);
        check_val("b_latency", lat, LAT);
        check_val("b_rsp_data", rsp_data, 4'b1111);
        check_val("b_rsp_unan", rsp_unanimous, 0);
        handshake();

        // 7 of 15 samples all-ones; non-sample cycles all-ones.
        mask = 15'b010101010101010; filler = 4'hF;
        run_query(1'b0, 2'b11, 2'b00, 4'b0000, 1'b0, lat, pend, viol);
        check_val("c_rsp_data", rsp_data, 4'b0000);
        check_val("c_rsp_unan", rsp_unanimous, 0);
        handshake();

        // All-ones during burn-in must not leak into the vote.
        stub_mode = 2;
        run_query(1'b0, 2'b10, 2'b10, 4'b0000, 1'b0, lat, pend, viol);
        check_val("d_rsp_data", rsp_data, 4'b0001);
        check_val("d_rsp_unan", rsp_unanimous, 1);
        handshake();

        // Inverse mode with a competing request held while busy.
        stub_mode = 0; const_val = 4'b0110;
        run_query(1'b1, 2'b00, 2'b00, 4'b0110, 1'b1, lat, pend, viol);
        check_val("e_latency", lat, LAT);
        check_val("e_busy_violations", viol, 0);
        check_val("e_psl_mode", psl_mode, 1);
        check_val("e_psl_op", psl_op, 4'b0110);
        check_val("e_rsp_mode", rsp_mode, 1);
        handshake();
        check_val("e_hs_req_ready", req_ready, 1);
        check_val("e_hs_op_not_taken", psl_op, 4'b0110);
        tick();
        acc_edge = edge_cnt;
        req_valid = 1'b0;
        check_val("f_accept_op", psl_op, 4'b1001);
        check_val("f_accept_mode", psl_mode, 0);
        check_val("f_accept_busy", req_ready, 0);

        // Abort that query in the middle of sampling.
        const_val = 4'hF;
        repeat (250) tick();
        check_val("f_pending_in_sample", psl_pending, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_val("f_rst_pending", psl_pending, 0);
        check_val("f_rst_req_ready", req_ready, 1);
        check_val("f_rst_rsp_valid", rsp_valid, 0);

        const_val = 4'h0;
        run_query(1'b0, 2'b01, 2'b10, 4'b0000, 1'b0, lat, pend, viol);
        check_val("g_latency", lat, LAT);
        check_val("g_rsp_data", rsp_data, 4'b0000);
        check_val("g_rsp_unan", rsp_unanimous, 1);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
